// File: rtl/clk_div_gen.sv
// clk_div_gen: two-stage periodic strobe generator.
// A prescaler counter feeds a main counter; a one-cycle tick marks the end of
// each (pre_tc+1)*(div_tc+1) clock period. New terminal counts are loaded
// through a shadow/pending handshake and take effect only at a period boundary
// (or at once while counting is disabled), so no partial period is ever emitted.
// Optional: define CLK_DIV_TOGGLE_EN to add the clk_out 50% square-wave output.
module clk_div_gen #(
    parameter int CNT_W       = 14,
    parameter int PRE_DEFAULT = 10000,
    parameter int DIV_DEFAULT = 10000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_pre,
    input  logic [CNT_W-1:0] cfg_div,
`ifdef CLK_DIV_TOGGLE_EN
    output logic             clk_out,
`endif
    output logic             cfg_ack,
    output logic             tick
);

    localparam logic [CNT_W-1:0] PRE_RST = CNT_W'(PRE_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] pre_tc_q,  pre_tc_d;
    logic [CNT_W-1:0] div_tc_q,  div_tc_d;
    logic [CNT_W-1:0] shd_pre_q, shd_pre_d;
    logic [CNT_W-1:0] shd_div_q, shd_div_d;
    logic             pending_q, pending_d;
    logic             tick_q,    tick_d;
    logic             ack_q,     ack_d;

    logic pre_stb;
    logic div_hit;
    logic bnd;
    logic apply;

    // Boundary detection and apply decision: a pending config lands on the
    // period boundary while running, or on the very next edge while stopped.
    always_comb begin
        pre_stb = en && (pre_cnt_q == pre_tc_q);
        div_hit = (div_cnt_q == div_tc_q);
        bnd     = pre_stb && div_hit;
        apply   = pending_q && (!en || bnd);
    end

    // Next-state for counters, terminal counts and the config handshake.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        div_cnt_d = div_cnt_q;
        pre_tc_d  = pre_tc_q;
        div_tc_d  = div_tc_q;
        shd_pre_d = shd_pre_q;
        shd_div_d = shd_div_q;
        pending_d = pending_q;
        tick_d    = bnd;
        ack_d     = apply;

        if (en) begin
            pre_cnt_d = pre_stb ? '0 : pre_cnt_q + 1'b1;
            if (pre_stb)
                div_cnt_d = div_hit ? '0 : div_cnt_q + 1'b1;
        end

        // Last load wins while pending; only one apply (and ack) follows.
        if (cfg_load) begin
            shd_pre_d = cfg_pre;
            shd_div_d = cfg_div;
            pending_d = 1'b1;
        end

        // A load arriving on the apply edge bypasses the shadow so it is not
        // left pending behind an ack that already reported it.
        if (apply) begin
            pre_tc_d  = cfg_load ? cfg_pre : shd_pre_q;
            div_tc_d  = cfg_load ? cfg_div : shd_div_q;
            pre_cnt_d = '0;
            div_cnt_d = '0;
            pending_d = 1'b0;
        end
    end

    // State registers; reset restores the default period and drops any load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            div_cnt_q <= '0;
            pre_tc_q  <= PRE_RST;
            div_tc_q  <= DIV_RST;
            shd_pre_q <= '0;
            shd_div_q <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            div_cnt_q <= div_cnt_d;
            pre_tc_q  <= pre_tc_d;
            div_tc_q  <= div_tc_d;
            shd_pre_q <= shd_pre_d;
            shd_div_q <= shd_div_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            ack_q     <= ack_d;
        end
    end

    assign tick    = tick_q;
    assign cfg_ack = ack_q;

`ifdef CLK_DIV_TOGGLE_EN
    logic clk_out_q, clk_out_d;

    // Square wave flips each boundary; a config apply restarts it low.
    always_comb begin
        clk_out_d = clk_out_q;
        if (apply)
            clk_out_d = 1'b0;
        else if (bnd)
            clk_out_d = !clk_out_q;
    end

    // Square-wave register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            clk_out_q <= 1'b0;
        else
            clk_out_q <= clk_out_d;
    end

    assign clk_out = clk_out_q;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen with CNT_W=8, PRE_DEFAULT=3, DIV_DEFAULT=4
// (default period 20 clocks). Edge numbers count edges after reset release;
// outputs are sampled 1 time unit after each rising edge.
module tb_clk_div_gen;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          cfg_load;
    logic [CW-1:0] cfg_pre;
    logic [CW-1:0] cfg_div;
    logic          cfg_ack;
    logic          tick;
`ifdef CLK_DIV_TOGGLE_EN
    logic          clk_out;
`endif

    int total = 0;
    int bad   = 0;

    clk_div_gen #(.CNT_W(CW), .PRE_DEFAULT(3), .DIV_DEFAULT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_load (cfg_load),
        .cfg_pre  (cfg_pre),
        .cfg_div  (cfg_div),
`ifdef CLK_DIV_TOGGLE_EN
        .clk_out  (clk_out),
`endif
        .cfg_ack  (cfg_ack),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle.
    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        cfg_load = 1'b0;
        cfg_pre  = '0;
        cfg_div  = '0;
        tk();
        tk();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_tick", tick, 0);
        chk("rst_ack", cfg_ack, 0);
`ifdef CLK_DIV_TOGGLE_EN
        chk("rst_clk_out", clk_out, 0);
`endif

        // Period check: ticks after edges 20, 40, 60
        en = 1'b1;
        for (int e = 1; e <= 62; e++) begin
            tk();
            chk($sformatf("period_tick_e%0d", e), tick, (e % 20 == 0) ? 1 : 0);
        end

        // Enable gating: en low on edges 10..16, first tick after edge 27
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            en = !(e >= 10 && e <= 16);
            tk();
            chk($sformatf("gate_tick_e%0d", e), tick, (e == 27) ? 1 : 0);
        end

        // Boundary reconfiguration: load at edge 5, applies at edge 20
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            cfg_load = (e == 5);
            cfg_pre  = 8'd1;
            cfg_div  = 8'd1;
            tk();
            chk($sformatf("recfg_tick_e%0d", e), tick,
                (e == 20 || (e > 20 && (e - 20) % 4 == 0)) ? 1 : 0);
            chk($sformatf("recfg_ack_e%0d", e), cfg_ack, (e == 20) ? 1 : 0);
        end
        cfg_load = 1'b0;

        // Idle load: en=0 applies next edge; then 0/0 gives continuous tick
        do_reset();
        cfg_load = 1'b1;
        cfg_pre  = 8'd0;
        cfg_div  = 8'd0;
        tk();
        cfg_load = 1'b0;
        chk("idle_ack_load_edge", cfg_ack, 0);
        tk();
        chk("idle_ack_apply", cfg_ack, 1);
        tk();
        chk("idle_ack_after", cfg_ack, 0);
        chk("idle_tick_off", tick, 0);
        en = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tk();
            chk($sformatf("extreme_tick_e%0d", e), tick, 1);
        end
        en = 1'b0;
        tk();
        chk("extreme_tick_en0", tick, 0);

        // Repeated load: edges 3 and 8, single ack at 20, second value (2,1) in force
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            cfg_load = (e == 3) || (e == 8);
            cfg_pre  = (e == 3) ? 8'd2 : 8'd1;
            cfg_div  = (e == 3) ? 8'd2 : 8'd0;
            tk();
            chk($sformatf("rep_ack_e%0d", e), cfg_ack, (e == 20) ? 1 : 0);
            chk($sformatf("rep_tick_e%0d", e), tick,
                (e == 20 || (e > 20 && e % 2 == 0)) ? 1 : 0);
        end
        cfg_load = 1'b0;

        // Reset mid-period with a load pending: no ack, defaults restored
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            cfg_load = (e == 3);
            cfg_pre  = 8'd0;
            cfg_div  = 8'd0;
            tk();
            chk($sformatf("prerst_tick_e%0d", e), tick, 0);
        end
        cfg_load = 1'b0;
        rst_n = 1'b0;
        tk();
        chk("midrst_tick", tick, 0);
        chk("midrst_ack", cfg_ack, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 41; e++) begin
            tk();
            chk($sformatf("postrst_tick_e%0d", e), tick, (e % 20 == 0) ? 1 : 0);
            chk($sformatf("postrst_ack_e%0d", e), cfg_ack, 0);
        end

`ifdef CLK_DIV_TOGGLE_EN
        // Toggle output: rises after 20, falls after 40, period 40
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 82; e++) begin
            tk();
            chk($sformatf("clk_out_e%0d", e), clk_out, ((e / 20) % 2 == 1) ? 1 : 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised two-stage clock divider that produces the system's periodic strobes, e.g. the baud/step tick and display scan tick.
- A prescaler counter feeds a main counter. Both terminal counts are loadable at run time through a load/ack handshake.
- Output is a one-cycle `tick` pulse per period, with gated enable and glitch-free reconfiguration at period boundaries.

Parameters:
- CNT_W, 14, width of both counters and both terminal-count registers.
- PRE_DEFAULT, 10000, prescaler terminal count after reset; prescaler period is PRE_DEFAULT+1 clocks.
- DIV_DEFAULT, 10000, main terminal count after reset; main period is DIV_DEFAULT+1 prescaler strobes.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  count enable; counters hold while low.
- cfg_load  input  1  single-cycle request to load new terminal counts.
- cfg_pre  input  CNT_W  new prescaler terminal count; sampled when cfg_load=1.
- cfg_div  input  CNT_W  new main terminal count; sampled when cfg_load=1.
- cfg_ack  output  1  one-cycle pulse when the new counts take effect.
- tick  output  1  one-cycle pulse at the end of each output period.
- clk_out  output  1  divided square wave; present only with CLK_DIV_TOGGLE_EN.

Behaviour:
- Reset is synchronous and active-low. When rst_n=0 at a clk edge:
  - pre_cnt=0, div_cnt=0.
  - pre_tc=PRE_DEFAULT, div_tc=DIV_DEFAULT.
  - Shadow registers are cleared and pending=0.
  - tick=0, cfg_ack=0, clk_out=0.
  - A pending load is discarded and no ack is issued.
- Counting, only when en=1:
  - pre_cnt increments by 1 each edge.
  - When pre_cnt==pre_tc, pre_cnt wraps to 0 and asserts internal strobe pre_stb in that state.
  - div_cnt increments only on pre_stb. When div_cnt==div_tc and pre_stb, div_cnt wraps to 0 (condition `bnd`).
- tick:
  - tick is registered: it is high for exactly the one cycle following the edge on which bnd was true.
  - Output period is (pre_tc+1)*(div_tc+1) clocks.
  - With pre_tc=0 and div_tc=0, bnd is true every cycle and tick stays high continuously while en=1.
- en=0:
  - Counters and tc registers hold.
  - tick=0 from the next edge.
  - On reassertion, counting resumes from the held values; there is no restart.
- Arithmetic:
  - Comparisons use equality only; no overflow is possible because counters wrap at their tc.
  - tc values of all-ones are legal.
- Config handshake:
  - cfg_load=1 captures cfg_pre/cfg_div into the shadow registers and sets pending.
  - A repeated load while pending overwrites the shadow (last wins); only one ack is issued.
- Apply rules:
  - If pending and en=1, apply on the edge where bnd is true.
  - If pending and en=0, apply on the next edge.
  - Apply means: pre_tc/div_tc take the shadow values, both counters go to 0, pending clears, and cfg_ack=1 for the following cycle.
  - On an apply at a boundary, tick still pulses for the period just completed.
- Simultaneous events:
  - cfg_load in the same cycle as an apply: the cfg_pre/cfg_div presented that cycle are applied directly, bypassing the shadow, with a single ack.
  - rst_n=0 wins over everything.
- Latency:
  - Load to ack is at most one full current period + 1 cycle with en=1, or 1 cycle with en=0.

Optional Feature:
- Macro: CLK_DIV_TOGGLE_EN.
- Defined:
  - Port clk_out exists.
  - clk_out toggles on every edge where bnd is true, giving a period of 2*(pre_tc+1)*(div_tc+1) clocks with 50% duty.
  - clk_out is reset to 0 and forced to 0 on a config apply.
  - clk_out holds its level while en=0.
- Not defined: port clk_out and its register are absent. All other behaviour is identical.

Test Plan:
- Period check. CNT_W=8, PRE_DEFAULT=3, DIV_DEFAULT=4; release reset, en=1.
  - tick is high for one cycle after the 20th enabled edge, again after the 40th and 60th, and low at all other times.
- Enable gating. Same parameters; drop en for 7 cycles at the 10th edge, then reassert.
  - First tick occurs after edge 27; there are no ticks while en=0.
- Boundary reconfiguration. Same parameters; at edge 5 pulse cfg_load with cfg_pre=1, cfg_div=1.
  - tick after edge 20, and cfg_ack after edge 20 in the same cycle.
  - Subsequent ticks every 4 cycles: after edges 24, 28, ….
- Load while idle or repeated load.
  - With en=0, a load applies with cfg_ack on the next cycle.
  - Two loads at edges 3 and 8 with en=1 yield a single ack, and the second value is in force.
- Extremes and reset.
  - cfg_pre=0, cfg_div=0 gives tick continuously high.
  - rst_n=0 mid-period with a load pending gives tick=0 and no ack, and the defaults are restored (period 20).
- Toggle output (CLK_DIV_TOGGLE_EN defined, defaults as above).
  - clk_out rises after edge 20, falls after edge 40, with period 40.
